// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One bit per cycle: shift-add multiply, restoring divide, sign fix on the way into DONE.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_ex,
   input  logic [2:0]      muldiv_op_ex,
   input  logic [XLEN-1:0] rs1_data_ex,
   input  logic [XLEN-1:0] rs2_data_ex,
   input  logic            advance_ex,
   input  logic            flush_ex,
   output logic            stall_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);
   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            r_state;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_b;
   logic [2*XLEN-1:0] r_acc;
   logic [CW-1:0]     r_cnt;
   logic              r_neg_q;
   logic              r_neg_r;
   logic [XLEN-1:0]   r_result;

   logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [XLEN-1:0]   w_a_mag, w_b_mag;
   logic              w_div_zero, w_ovf, w_special;
   logic [XLEN-1:0]   w_special_res;
   logic [XLEN:0]     w_sum, w_shift, w_diff;
   logic [2*XLEN-1:0] w_mul_next, w_div_next, w_acc_next, w_prod;
   logic [XLEN-1:0]   w_quo, w_rem, w_final;

   // Sign handling at capture: MUL is treated as signed, the low word is the same either way.
   assign w_a_signed = muldiv_op_ex[2] ? ~muldiv_op_ex[0] : (muldiv_op_ex[1:0] != 2'b11);
   assign w_b_signed = muldiv_op_ex[2] ? ~muldiv_op_ex[0] : ~muldiv_op_ex[1];
   assign w_a_neg    = w_a_signed & rs1_data_ex[XLEN-1];
   assign w_b_neg    = w_b_signed & rs2_data_ex[XLEN-1];
   assign w_a_mag    = w_a_neg ? -rs1_data_ex : rs1_data_ex;
   assign w_b_mag    = w_b_neg ? -rs2_data_ex : rs2_data_ex;

   assign w_div_zero    = muldiv_op_ex[2] & (rs2_data_ex == '0);
   assign w_ovf         = muldiv_op_ex[2] & ~muldiv_op_ex[0]
                        & (rs1_data_ex == {1'b1, {(XLEN-1){1'b0}}})
                        & (rs2_data_ex == '1);
   assign w_special     = w_div_zero | w_ovf;
   assign w_special_res = w_div_zero ? (muldiv_op_ex[1] ? rs1_data_ex : '1)
                                     : (muldiv_op_ex[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

   // Multiply: upper half accumulates, multiplier bits shift out of the bottom.
   assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
   assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

   // Divide: upper half is the partial remainder, lower half the dividend turning into the quotient.
   assign w_shift    = r_acc[2*XLEN-1:XLEN-1];
   assign w_diff     = w_shift - {1'b0, r_b};
   assign w_div_next = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
   assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

   assign w_prod = r_neg_q ? -w_acc_next : w_acc_next;
   assign w_quo  = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
   assign w_rem  = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

   always_comb begin
      w_final = w_prod[2*XLEN-1:XLEN];
      case (r_op)
         3'b000:         w_final = w_prod[XLEN-1:0];
         3'b100, 3'b101: w_final = w_quo;
         3'b110, 3'b111: w_final = w_rem;
         default:        w_final = w_prod[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_ex && !flush_ex) begin
                  r_op    <= muldiv_op_ex;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  if (w_special) begin
                     r_result <= w_special_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_acc   <= muldiv_op_ex[2] ? {{XLEN{1'b0}}, w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
                     r_b     <= muldiv_op_ex[2] ? w_b_mag : w_a_mag;
                     r_cnt   <= CW'(XLEN-1);
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (flush_ex) begin
                  r_state <= S_IDLE;
               end else begin
                  r_acc <= w_acc_next;
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == '0) begin
                     r_result <= w_final;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (flush_ex || advance_ex)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Stall is combinational so a flush releases the pipeline in the same cycle.
   assign stall_o        = rst_n & ~flush_ex
                         & (((r_state == S_IDLE) & start_ex) | (r_state == S_BUSY));
   assign busy_o         = (r_state == S_BUSY);
   assign result_valid_o = (r_state == S_DONE);
   assign result_o       = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed and random M-ops compared cycle by cycle
// against an arithmetic reference and the documented latency rules.
module tb_ex_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_ex = 1'b0;
   logic [2:0]  muldiv_op_ex = '0;
   logic [31:0] rs1_data_ex = '0;
   logic [31:0] rs2_data_ex = '0;
   logic        advance_ex = 1'b0;
   logic        flush_ex = 1'b0;
   logic        stall_o, result_valid_o, busy_o;
   logic [31:0] result_o;

   int checks = 0;
   int failures = 0;

   logic        chk_en = 1'b0;
   logic        exp_stall, exp_valid, exp_busy;
   logic [31:0] exp_res;
   string       cur_name = "";

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_ex(start_ex), .muldiv_op_ex(muldiv_op_ex),
      .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .advance_ex(advance_ex),
      .flush_ex(flush_ex), .stall_o(stall_o), .result_valid_o(result_valid_o),
      .result_o(result_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference: plain 64-bit arithmetic plus the RISC-V special-case rules.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Single compare process: every cycle while enabled, outputs vs expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         check({cur_name, ".stall"}, {31'd0, stall_o}, {31'd0, exp_stall});
         check({cur_name, ".busy"},  {31'd0, busy_o},  {31'd0, exp_busy});
         check({cur_name, ".valid"}, {31'd0, result_valid_o}, {31'd0, exp_valid});
         if (exp_valid) check({cur_name, ".result"}, result_o, exp_res);
      end
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         start_ex = 1'b0; flush_ex = 1'b0; advance_ex = 1'($urandom_range(0, 1));
         exp_stall = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
         cur_name = "idle";
         @(posedge clk); #1;
      end
   endtask

   // One instruction sitting in EX: cycle 0 is the IDLE cycle that sees it.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int flush_at, input int hold);
      bit special;
      int lat;
      bit fl;
      special = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      lat = special ? 1 : 33;
      exp_res = model(op, a, b);
      cur_name = name;
      for (int k = 0; k <= lat + hold; k++) begin
         fl = (k == flush_at);
         start_ex = 1'b1; muldiv_op_ex = op; rs1_data_ex = a; rs2_data_ex = b;
         flush_ex = fl;
         if (k < lat)              advance_ex = 1'($urandom_range(0, 1));
         else if (k < lat + hold)  advance_ex = 1'b0;
         else                      advance_ex = 1'b1;
         exp_stall = !fl && (k < lat);
         exp_busy  = !special && (k >= 1) && (k < lat);
         exp_valid = (k >= lat);
         @(posedge clk); #1;
         if (fl) break;
      end
      $display("op=%0d a=%h b=%h expected=%h flush_at=%0d hold=%0d %s",
               op, a, b, exp_res, flush_at, hold, name);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      // Hand-computed values pinning the reference model.
      check("pin.mul",    model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      check("pin.mulhu",  model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      check("pin.mulh",   model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);
      check("pin.mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
      check("pin.div",    model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("pin.rem",    model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      check("pin.divu",   model(3'd5, 32'd100, 32'd7), 32'd14);
      check("pin.remu",   model(3'd7, 32'd100, 32'd7), 32'd2);
      check("pin.divu0",  model(3'd5, 32'h1234, 32'd0), 32'hFFFF_FFFF);
      check("pin.rem0",   model(3'd6, 32'h1234, 32'd0), 32'h1234);
      check("pin.divovf", model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      check("pin.removf", model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

      // Reset state
      #1;
      check("reset.stall",  {31'd0, stall_o}, 32'd0);
      check("reset.valid",  {31'd0, result_valid_o}, 32'd0);
      check("reset.busy",   {31'd0, busy_o}, 32'd0);
      check("reset.result", result_o, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      idle(2);

      // Directed operations
      run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, -1, 0);
      idle(1);
      run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0);
      run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, -1, 0);
      run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, -1, 0);
      run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, -1, 0);
      run_op("divu",   3'd5, 32'd100, 32'd7, -1, 0);
      run_op("remu",   3'd7, 32'd100, 32'd7, -1, 0);
      run_op("divu0",  3'd5, 32'h1234, 32'd0, -1, 0);
      run_op("rem0",   3'd6, 32'h1234, 32'd0, -1, 0);
      run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
      run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
      run_op("divflush", 3'd4, 32'd1000, 32'd7, 10, 0);
      run_op("divu9_3",  3'd5, 32'd9, 32'd3, -1, 5);
      idle(1);

      // Asynchronous reset in the middle of an operation
      run_op("mulrst", 3'd0, 32'd123, 32'd456, 5, 0);
      chk_en = 1'b0;
      start_ex = 1'b1; flush_ex = 1'b0; muldiv_op_ex = 3'd4;
      rs1_data_ex = 32'd5000; rs2_data_ex = 32'd3; advance_ex = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("midbusy.busy", {31'd0, busy_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("asyncrst.stall",  {31'd0, stall_o}, 32'd0);
      check("asyncrst.valid",  {31'd0, result_valid_o}, 32'd0);
      check("asyncrst.busy",   {31'd0, busy_o}, 32'd0);
      check("asyncrst.result", result_o, 32'd0);
      start_ex = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      idle(1);
      run_op("afterrst", 3'd5, 32'd5000, 32'd3, -1, 0);

      // Randomized operations with random holds, occasional flushes and gaps
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         int fa, hd;
         op = 3'($urandom_range(0, 7));
         a  = rnd_operand();
         b  = rnd_operand();
         hd = $urandom_range(0, 3);
         fa = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 36) : -1;
         run_op("rand", op, a, b, fa, hd);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      idle(2);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
